// File: rtl/bus_mm_pkg.sv
// bus_pkg: shared types and helpers for the bus_mm multi-master bus.
//   bus_state_t   : arbiter state (IDLE = no owner, BUSY = owner holds the bus)
//   BUS_AW/DW/... : default address/data/window widths
//   onehot_to_idx : one-hot (up to 8 bits) to binary index, used by the
//                   arbiter (winner -> owner) and the read mux (rsel -> slave)
package bus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } bus_state_t;

    localparam int BUS_AW        = 16;
    localparam int BUS_DW        = 64;
    localparam int BUS_WIN_BITS  = 5;
    localparam int BUS_MAX_PORTS = 8;
    localparam int OWNER_W       = 3;

    // Input must be one-hot or zero; zero maps to index 0.
    function automatic logic [OWNER_W-1:0] onehot_to_idx(input logic [BUS_MAX_PORTS-1:0] oh);
        logic [OWNER_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < BUS_MAX_PORTS; i++) begin
            if (oh[i]) begin
                idx = idx | OWNER_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/bus_mm_if.sv
// bus_mm_if: bundle of all master-side and slave-side bus signals.
// Modports are seen from the bus fabric:
//   master : fabric port facing the masters (req/wr/addr/dout in, grant/din out)
//   slave  : fabric port facing the slaves  (sel/wr/addr/din out, dout in)
// Master i uses bits [i*AW +: AW] / [i*DW +: DW]; slave k uses [k*DW +: DW].
interface bus_mm_if
    import bus_pkg::*;
#(
    parameter int NUM_M = 2,
    parameter int NUM_S = 2,
    parameter int AW    = BUS_AW,
    parameter int DW    = BUS_DW
) ();

    logic [NUM_M-1:0]    m_req;
    logic [NUM_M-1:0]    m_wr;
    logic [NUM_M*AW-1:0] m_addr;
    logic [NUM_M*DW-1:0] m_dout;
    logic [NUM_M-1:0]    m_grant;
    logic [DW-1:0]       m_din;

    logic [NUM_S-1:0]    s_sel;
    logic                s_wr;
    logic [AW-1:0]       s_addr;
    logic [DW-1:0]       s_din;
    logic [NUM_S*DW-1:0] s_dout;

    modport master (
        input  m_req, m_wr, m_addr, m_dout,
        output m_grant, m_din
    );

    modport slave (
        output s_sel, s_wr, s_addr, s_din,
        input  s_dout
    );

endinterface

// File: rtl/bus_mm_arbiter.sv
// bus_mm_arbiter: two-state arbiter owning the bus owner register and grant.
//   clk, reset_n : clock, asynchronous active-low reset
//   req          : per-master request
//   grant        : registered one-hot of the owner (zero when IDLE)
//   owner        : registered owner index
//   busy         : high in BUSY
// Policy macro BUS_RR_EN: defined -> round robin starting after the last
// owner; undefined -> fixed priority, lowest index wins.
module bus_mm_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_M = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_M-1:0]    req,
    output logic [NUM_M-1:0]    grant,
    output logic [OWNER_W-1:0]  owner,
    output logic                busy
);

    bus_state_t         state, next_state;
    logic [OWNER_W-1:0] next_owner;
    logic [OWNER_W-1:0] pick_idx;
    logic [NUM_M-1:0]   pick_oh;
    logic [NUM_M-1:0]   next_grant;
    logic               owner_req;

`ifdef BUS_RR_EN
    int rr_dist;
    int rr_best;

    // Smallest distance from owner+1 (mod NUM_M) wins, so the last owner is
    // the farthest candidate and therefore lowest priority.
    always_comb begin
        pick_oh = '0;
        rr_dist = 0;
        rr_best = NUM_M;
        for (int i = 0; i < NUM_M; i++) begin
            if (req[i]) begin
                rr_dist = (i + NUM_M - int'(owner) - 1) % NUM_M;
                if (rr_dist < rr_best) begin
                    rr_best    = rr_dist;
                    pick_oh    = '0;
                    pick_oh[i] = 1'b1;
                end
            end
        end
    end
`else
    // Scanning downward lets the lowest requesting index overwrite the rest.
    always_comb begin
        pick_oh = '0;
        for (int i = NUM_M - 1; i >= 0; i--) begin
            if (req[i]) begin
                pick_oh    = '0;
                pick_oh[i] = 1'b1;
            end
        end
    end
`endif

    assign pick_idx  = onehot_to_idx(BUS_MAX_PORTS'(pick_oh));
    // grant is the owner's one-hot while BUSY, so it doubles as an owner mask.
    assign owner_req = |(req & grant);
    assign busy      = (state == BUSY);

    always_comb begin
        next_state = state;
        next_owner = owner;
        next_grant = '0;
        case (state)
            IDLE: begin
                if (|req) begin
                    next_state = BUSY;
                    next_owner = pick_idx;
                end
            end
            BUSY: begin
                if (!owner_req) begin
                    if (|req) begin
                        next_owner = pick_idx;
                    end else begin
                        next_state = IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
        if (next_state == BUSY) begin
            for (int i = 0; i < NUM_M; i++) begin
                next_grant[i] = (next_owner == OWNER_W'(i));
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            owner <= '0;
            grant <= '0;
        end else begin
            state <= next_state;
            owner <= next_owner;
            grant <= next_grant;
        end
    end

endmodule

// File: rtl/bus_mm.sv
// bus_mm: parametrised multi-master, multi-slave shared bus.
//   clk, reset_n : clock, asynchronous active-low reset
//   mst          : master side (m_req, m_wr, m_addr, m_dout in; m_grant, m_din out)
//   slv          : slave side (s_sel, s_wr, s_addr, s_din out; s_dout in)
// Slave k window: BASE + k*2^WIN_BITS .. BASE + (k+1)*2^WIN_BITS - 1; accesses
// outside every window select nothing. Read data returns one cycle after the
// address through the registered select rsel.
// Optional macro BUS_RR_EN selects round-robin arbitration (default fixed priority).
module bus_mm
    import bus_pkg::*;
#(
    parameter int            NUM_M    = 2,
    parameter int            NUM_S    = 2,
    parameter int            AW       = BUS_AW,
    parameter int            DW       = BUS_DW,
    parameter int            WIN_BITS = BUS_WIN_BITS,
    parameter logic [AW-1:0] BASE     = '0
) (
    input  logic     clk,
    input  logic     reset_n,
    bus_mm_if.master mst,
    bus_mm_if.slave  slv
);

    logic [OWNER_W-1:0] owner;
    logic               busy;
    logic               wr_mux;
    logic [AW-1:0]      addr_mux;
    logic [DW-1:0]      din_mux;
    logic [AW-1:0]      offset;
    logic [AW-1:0]      window;
    logic [NUM_S-1:0]   sel;
    logic [NUM_S-1:0]   rsel;
    logic [OWNER_W-1:0] ridx;
    logic [DW-1:0]      rdata;

    bus_mm_arbiter #(.NUM_M(NUM_M)) u_arbiter (
        .clk     (clk),
        .reset_n (reset_n),
        .req     (mst.m_req),
        .grant   (mst.m_grant),
        .owner   (owner),
        .busy    (busy)
    );

    // The owner's request fields drive the slaves directly; nothing is latched.
    always_comb begin
        wr_mux   = 1'b0;
        addr_mux = '0;
        din_mux  = '0;
        if (busy) begin
            for (int i = 0; i < NUM_M; i++) begin
                if (owner == OWNER_W'(i)) begin
                    wr_mux   = mst.m_wr[i];
                    addr_mux = mst.m_addr[i*AW +: AW];
                    din_mux  = mst.m_dout[i*DW +: DW];
                end
            end
        end
    end

    // The >= BASE test gates the subtraction result, so a wrapped offset
    // below BASE never selects a slave.
    always_comb begin
        sel    = '0;
        offset = addr_mux - BASE;
        window = offset >> WIN_BITS;
        if (busy && (addr_mux >= BASE)) begin
            for (int k = 0; k < NUM_S; k++) begin
                if (window == AW'(k)) begin
                    sel[k] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsel <= '0;
        end else begin
            rsel <= sel;
        end
    end

    always_comb begin
        ridx  = onehot_to_idx(BUS_MAX_PORTS'(rsel));
        rdata = '0;
        if (|rsel) begin
            for (int k = 0; k < NUM_S; k++) begin
                if (ridx == OWNER_W'(k)) begin
                    rdata = slv.s_dout[k*DW +: DW];
                end
            end
        end
    end

    assign slv.s_sel  = sel;
    assign slv.s_wr   = wr_mux;
    assign slv.s_addr = addr_mux;
    assign slv.s_din  = din_mux;
    assign mst.m_din  = rdata;

endmodule

// File: tb/tb_bus_mm.sv
// tb_bus_mm: self-checking bench for bus_mm (2 masters, 2 slaves, BASE 0,
// 32-word windows). Inputs change 1 ns after the rising edge and outputs are
// sampled on the falling edge. A cycle table covers writes, reads, window
// edges and out-of-window accesses, with read data tracked through a queue;
// hand sequences cover reset, arbitration policy and async reset mid-read.
module tb_bus_mm;

    localparam int            NUM_M = 2;
    localparam int            NUM_S = 2;
    localparam int            AW    = 16;
    localparam int            DW    = 64;
    localparam logic [63:0]   SD0   = 64'h0000_0000_0000_1234;
    localparam logic [63:0]   SD1   = 64'hBEEF_0000_0000_0001;

    typedef struct {
        logic [1:0]  req;
        logic [1:0]  wr;
        logic [15:0] addr0;
        logic [15:0] addr1;
        logic [63:0] dout0;
        logic [63:0] dout1;
        logic [1:0]  grant;
        logic [1:0]  sel;
        logic        swr;
        logic [15:0] saddr;
        logic [63:0] sdin;
        logic [63:0] din_next;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n;
    int   compared = 0;
    int   mismatched = 0;
    logic [63:0] din_q[$];
    vec_t tbl[12];

    always #5 clk = ~clk;

    bus_mm_if #(.NUM_M(NUM_M), .NUM_S(NUM_S), .AW(AW), .DW(DW)) bif ();

    bus_mm #(
        .NUM_M    (NUM_M),
        .NUM_S    (NUM_S),
        .AW       (AW),
        .DW       (DW),
        .WIN_BITS (5),
        .BASE     (16'h0000)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .mst     (bif),
        .slv     (bif)
    );

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] req, input logic [1:0] wr,
                                input logic [15:0] a0, input logic [15:0] a1,
                                input logic [63:0] d0, input logic [63:0] d1,
                                input logic [1:0] g, input logic [1:0] sel,
                                input logic swr, input logic [15:0] sa,
                                input logic [63:0] sd, input logic [63:0] dn);
        vec_t v;
        v.req = req; v.wr = wr; v.addr0 = a0; v.addr1 = a1;
        v.dout0 = d0; v.dout1 = d1; v.grant = g; v.sel = sel;
        v.swr = swr; v.saddr = sa; v.sdin = sd; v.din_next = dn;
        return v;
    endfunction

    task automatic apply_stimulus(input vec_t v);
        bif.m_req  = v.req;
        bif.m_wr   = v.wr;
        bif.m_addr = {v.addr1, v.addr0};
        bif.m_dout = {v.dout1, v.dout0};
    endtask

    task automatic check_output(input vec_t v, input int row);
        logic [63:0] exp_din;
        check_val($sformatf("r%0d grant", row), 64'(bif.m_grant), 64'(v.grant));
        check_val($sformatf("r%0d s_sel", row), 64'(bif.s_sel), 64'(v.sel));
        check_val($sformatf("r%0d s_wr", row), 64'(bif.s_wr), 64'(v.swr));
        check_val($sformatf("r%0d s_addr", row), 64'(bif.s_addr), 64'(v.saddr));
        check_val($sformatf("r%0d s_din", row), bif.s_din, v.sdin);
        if (din_q.size() == 0) begin
            check_val($sformatf("r%0d m_din queue empty", row), 64'(1), 64'(0));
        end else begin
            exp_din = din_q.pop_front();
            check_val($sformatf("r%0d m_din", row), bif.m_din, exp_din);
        end
        din_q.push_back(v.din_next);
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, " grant"}, 64'(bif.m_grant), 64'(0));
        check_val({tag, " m_din"}, bif.m_din, 64'(0));
        check_val({tag, " s_sel"}, 64'(bif.s_sel), 64'(0));
        check_val({tag, " s_wr"}, 64'(bif.s_wr), 64'(0));
        check_val({tag, " s_addr"}, 64'(bif.s_addr), 64'(0));
        check_val({tag, " s_din"}, bif.s_din, 64'(0));
    endtask

    // Reset pulse placed between edges; leaves the bench at a falling edge
    // with all requests low so the arbiter starts IDLE with owner 0.
    task automatic do_reset();
        @(negedge clk);
        bif.m_req = 2'b00;
        reset_n   = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [1:0] g;
        logic [1:0] exp_g;

        reset_n    = 1'b0;
        bif.m_req  = 2'b11;
        bif.m_wr   = 2'b00;
        bif.m_addr = {16'h0025, 16'h0003};
        bif.m_dout = {64'hA5, 64'h77};
        bif.s_dout = {SD1, SD0};

        // Reset held with every master requesting.
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset_n = 1'b1;
        @(negedge clk);
`ifdef BUS_RR_EN
        check_val("reset release grant", 64'(bif.m_grant), 64'(2'b10));
`else
        check_val("reset release grant", 64'(bif.m_grant), 64'(2'b01));
`endif

        // Cycle table.
        tbl[0]  = mk(2'b10, 2'b10, 16'h0003, 16'h0025, 64'h77, 64'hA5, 2'b00, 2'b00, 1'b0, 16'h0000, 64'h0, 64'h0);
        tbl[1]  = mk(2'b10, 2'b10, 16'h0003, 16'h0025, 64'h77, 64'hA5, 2'b10, 2'b10, 1'b1, 16'h0025, 64'hA5, SD1);
        tbl[2]  = mk(2'b00, 2'b10, 16'h0003, 16'h0025, 64'h77, 64'hA5, 2'b10, 2'b10, 1'b1, 16'h0025, 64'hA5, SD1);
        tbl[3]  = mk(2'b01, 2'b00, 16'h0003, 16'h0025, 64'h77, 64'hA5, 2'b00, 2'b00, 1'b0, 16'h0000, 64'h0, 64'h0);
        tbl[4]  = mk(2'b01, 2'b00, 16'h0003, 16'h0025, 64'h77, 64'hA5, 2'b01, 2'b01, 1'b0, 16'h0003, 64'h77, SD0);
        tbl[5]  = mk(2'b01, 2'b00, 16'h0040, 16'h0025, 64'h77, 64'hA5, 2'b01, 2'b00, 1'b0, 16'h0040, 64'h77, 64'h0);
        tbl[6]  = mk(2'b00, 2'b00, 16'h0040, 16'h0025, 64'h77, 64'hA5, 2'b01, 2'b00, 1'b0, 16'h0040, 64'h77, 64'h0);
        tbl[7]  = mk(2'b00, 2'b00, 16'h0040, 16'h0025, 64'h77, 64'hA5, 2'b00, 2'b00, 1'b0, 16'h0000, 64'h0, 64'h0);
        tbl[8]  = mk(2'b01, 2'b01, 16'h003F, 16'h0025, 64'hDEAD, 64'hA5, 2'b00, 2'b00, 1'b0, 16'h0000, 64'h0, 64'h0);
        tbl[9]  = mk(2'b01, 2'b01, 16'h003F, 16'h0025, 64'hDEAD, 64'hA5, 2'b01, 2'b10, 1'b1, 16'h003F, 64'hDEAD, SD1);
        tbl[10] = mk(2'b00, 2'b01, 16'h0020, 16'h0025, 64'hDEAD, 64'hA5, 2'b01, 2'b10, 1'b1, 16'h0020, 64'hDEAD, SD1);
        tbl[11] = mk(2'b00, 2'b01, 16'h0020, 16'h0025, 64'hDEAD, 64'hA5, 2'b00, 2'b00, 1'b0, 16'h0000, 64'h0, 64'h0);

        do_reset();
        din_q.delete();
        din_q.push_back(64'h0);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            apply_stimulus(tbl[i]);
            @(negedge clk);
            check_output(tbl[i], i);
        end
        @(negedge clk);
        if (din_q.size() != 0) begin
            check_val("table tail m_din", bif.m_din, din_q.pop_front());
        end

        // Back-to-back handoff: a granted master drops its request in its
        // grant cycle; the grant must move with no idle cycle between.
        do_reset();
        @(posedge clk);
        #1;
        bif.m_wr  = 2'b00;
        bif.m_req = 2'b11;
        @(negedge clk);
        check_val("handoff c0 grant", 64'(bif.m_grant), 64'(0));
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            g = bif.m_grant;
            bif.m_req = ~g;
`ifdef BUS_RR_EN
            exp_g = (c % 2 == 1) ? 2'b10 : 2'b01;
`else
            exp_g = (c % 2 == 1) ? 2'b01 : 2'b10;
`endif
            @(negedge clk);
            check_val($sformatf("handoff c%0d grant", c), 64'(bif.m_grant), 64'(exp_g));
        end

        // Both masters request together from IDLE each round.
        do_reset();
        for (int r = 0; r < 4; r++) begin
            @(posedge clk);
            #1;
            bif.m_req = 2'b11;
            @(negedge clk);
            check_val($sformatf("idle r%0d grant", r), 64'(bif.m_grant), 64'(0));
            @(posedge clk);
            #1;
            bif.m_req = 2'b00;
`ifdef BUS_RR_EN
            exp_g = (r % 2 == 0) ? 2'b10 : 2'b01;
`else
            exp_g = 2'b01;
`endif
            @(negedge clk);
            check_val($sformatf("arb r%0d grant", r), 64'(bif.m_grant), 64'(exp_g));
        end

        // Asynchronous reset in the middle of a read.
        do_reset();
        @(posedge clk);
        #1;
        bif.m_wr   = 2'b00;
        bif.m_addr = {16'h0025, 16'h0003};
        bif.m_req  = 2'b01;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("midread grant", 64'(bif.m_grant), 64'(2'b01));
        check_val("midread m_din", bif.m_din, SD0);
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("async reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
